// File: rtl/transducer_array_fire_ctrl_if.sv
// Control, configuration and drive bundle between the sequencing/timing
// controller (master) and the multi-channel transducer fire controller (slave).
interface transducer_array_fire_ctrl_if #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned CT_W = 9,
  parameter int unsigned PD_W = 16,
  parameter int unsigned FD_W = 32,
  parameter int unsigned NP_W = 8,
  parameter int unsigned RT_W = 16
);
  logic                  enable;
  logic                  arm;
  logic                  fire;
  logic                  abort;
  logic [NCH-1:0]        chanMask;
  logic [CT_W-1:0]       chargeTime;
  logic [RT_W-1:0]       restTime;
  logic [NP_W-1:0]       pulseCount;
  logic [FD_W-1:0]       fireDelay;
  logic [NCH*PD_W-1:0]   phaseDelay;
  logic [NCH-1:0]        transducerOutput;
  logic                  busy;
  logic                  fireComplete;

  modport master (
    output enable, arm, fire, abort, chanMask, chargeTime, restTime,
           pulseCount, fireDelay, phaseDelay,
    input  transducerOutput, busy, fireComplete
  );

  modport slave (
    input  enable, arm, fire, abort, chanMask, chargeTime, restTime,
           pulseCount, fireDelay, phaseDelay,
    output transducerOutput, busy, fireComplete
  );
endinterface

// File: rtl/transducer_array_fire_ctrl.sv
// Multi-channel, multi-pulse transducer fire controller. A common fire event
// starts NCH channels; each waits fireDelay + its own phase delay, then emits
// pulseCount pulses of chargeTime high cycles separated by max(restTime,1)
// low cycles. All outputs are registered.
module transducer_array_fire_ctrl #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned CT_W = 9,
  parameter int unsigned PD_W = 16,
  parameter int unsigned FD_W = 32,
  parameter int unsigned NP_W = 8,
  parameter int unsigned RT_W = 16
) (
  input logic                        clk,
  input logic                        rst,
  transducer_array_fire_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FIRING,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic            busy_q, busy_nxt;
  logic            fc_q, fc_nxt;
  logic            do_latch, do_clear, do_step;
  logic            all_done_nxt;

  logic [CT_W-1:0] chg_l;
  logic [RT_W-1:0] rest_l;

  logic [FD_W:0]   dly      [NCH];
  logic [CT_W-1:0] chg      [NCH];
  logic [RT_W-1:0] rcnt     [NCH];
  logic [NP_W-1:0] npl      [NCH];
  logic [NCH-1:0]  out_q;

  logic [FD_W:0]   dly_nxt  [NCH];
  logic [CT_W-1:0] chg_nxt  [NCH];
  logic [RT_W-1:0] rcnt_nxt [NCH];
  logic [NP_W-1:0] npl_nxt  [NCH];
  logic [NCH-1:0]  out_nxt;

  logic [FD_W:0]   ld_dly   [NCH];
  logic [NP_W-1:0] ld_npl   [NCH];

  // Configuration values captured on arm: summed delay and pulse budget per channel.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ld_dly[i] = {1'b0, bus.fireDelay}
                + {{(FD_W + 1 - PD_W){1'b0}}, bus.phaseDelay[i*PD_W +: PD_W]};
      // A masked channel or a zero-length pulse is done before it starts.
      ld_npl[i] = (bus.chanMask[i] && (bus.chargeTime != '0)) ? bus.pulseCount : '0;
    end
  end

  // Per-channel pulse sequencer step; a channel with no pulses left is done.
  always_comb begin
    all_done_nxt = 1'b1;
    out_nxt      = out_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      dly_nxt[i]  = dly[i];
      chg_nxt[i]  = chg[i];
      rcnt_nxt[i] = rcnt[i];
      npl_nxt[i]  = npl[i];
      if (npl[i] != '0) begin
        if (out_q[i]) begin
          if (chg[i] != '0) begin
            chg_nxt[i] = chg[i] - 1'b1;
          end else begin
            out_nxt[i]  = 1'b0;
            npl_nxt[i]  = npl[i] - 1'b1;
            // Rest of zero is clamped to one low cycle.
            rcnt_nxt[i] = (rest_l == '0) ? '0 : rest_l - 1'b1;
          end
        end else if (dly[i] != '0) begin
          dly_nxt[i] = dly[i] - 1'b1;
        end else if (rcnt[i] != '0) begin
          rcnt_nxt[i] = rcnt[i] - 1'b1;
        end else begin
          out_nxt[i] = 1'b1;
          chg_nxt[i] = chg_l - 1'b1;
        end
      end
      if (npl_nxt[i] != '0) begin
        all_done_nxt = 1'b0;
      end
    end
  end

  // Top-level sequencing: next state, latch/clear strobes and registered status.
  always_comb begin
    state_nxt = state;
    fc_nxt    = fc_q;
    do_latch  = 1'b0;
    do_clear  = 1'b0;
    do_step   = 1'b0;
    if (!bus.enable) begin
      state_nxt = S_IDLE;
      do_clear  = 1'b1;
      fc_nxt    = 1'b1;
    end else if (bus.abort) begin
      state_nxt = S_IDLE;
      do_clear  = 1'b1;
      fc_nxt    = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            do_latch  = 1'b1;
            fc_nxt    = 1'b0;
            state_nxt = bus.fire ? S_FIRING : S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.fire) begin
            state_nxt = S_FIRING;
          end
        end
        S_FIRING: begin
          // The last falling edge and the move to DONE share the same clock edge.
          do_step = 1'b1;
          if (all_done_nxt) begin
            state_nxt = S_DONE;
            fc_nxt    = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_FIRING);
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      fc_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy_nxt;
      fc_q   <= fc_nxt;
    end
  end

  // Latched configuration and per-channel counters/outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg_l  <= '0;
      rest_l <= '0;
      out_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dly[i]  <= '0;
        chg[i]  <= '0;
        rcnt[i] <= '0;
        npl[i]  <= '0;
      end
    end else if (do_clear) begin
      out_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dly[i]  <= '0;
        chg[i]  <= '0;
        rcnt[i] <= '0;
        npl[i]  <= '0;
      end
    end else if (do_latch) begin
      chg_l  <= bus.chargeTime;
      rest_l <= bus.restTime;
      out_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dly[i]  <= ld_dly[i];
        chg[i]  <= '0;
        rcnt[i] <= '0;
        npl[i]  <= ld_npl[i];
      end
    end else if (do_step) begin
      out_q <= out_nxt;
      for (int unsigned i = 0; i < NCH; i++) begin
        dly[i]  <= dly_nxt[i];
        chg[i]  <= chg_nxt[i];
        rcnt[i] <= rcnt_nxt[i];
        npl[i]  <= npl_nxt[i];
      end
    end
  end

  assign bus.transducerOutput = out_q;
  assign bus.busy             = busy_q;
  assign bus.fireComplete     = fc_q;

endmodule

// File: tb/tb_transducer_array_fire_ctrl.sv
// Directed bench for transducer_array_fire_ctrl. A behavioural model derives
// each channel's drive from closed-form pulse timing relative to the fire edge.
module tb_transducer_array_fire_ctrl;

  localparam int unsigned NCH  = 8;
  localparam int unsigned CT_W = 9;
  localparam int unsigned PD_W = 16;
  localparam int unsigned FD_W = 32;
  localparam int unsigned NP_W = 8;
  localparam int unsigned RT_W = 16;

  typedef enum int {M_IDLE, M_ARMED, M_FIRING, M_DONE} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  transducer_array_fire_ctrl_if #(
    .NCH(NCH), .CT_W(CT_W), .PD_W(PD_W), .FD_W(FD_W), .NP_W(NP_W), .RT_W(RT_W)
  ) bus ();

  transducer_array_fire_ctrl #(
    .NCH(NCH), .CT_W(CT_W), .PD_W(PD_W), .FD_W(FD_W), .NP_W(NP_W), .RT_W(RT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Model state
  mode_t   m_mode = M_IDLE;
  logic    m_fc   = 1'b0;
  longint  cyc    = 0;
  longint  e0     = 0;
  longint  m_end  = 1;
  longint  m_dly [NCH];
  logic    m_act [NCH];
  longint  m_ct  = 0;
  longint  m_rt  = 0;
  longint  m_np  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_latch();
    longint gap;
    longint last;
    m_ct  = longint'(bus.chargeTime);
    m_rt  = longint'(bus.restTime);
    m_np  = longint'(bus.pulseCount);
    gap   = (m_rt == 0) ? 1 : m_rt;
    m_end = 1;
    for (int i = 0; i < NCH; i++) begin
      m_dly[i] = longint'(bus.fireDelay) + longint'(bus.phaseDelay[i*PD_W +: PD_W]);
      m_act[i] = bus.chanMask[i] && (m_ct != 0) && (m_np != 0);
      if (m_act[i]) begin
        last = m_dly[i] + 1 + (m_np - 1) * (m_ct + gap) + m_ct;
        if (last > m_end) m_end = last;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_out();
    logic [NCH-1:0] v;
    longint k, s, per, off;
    v = '0;
    k = cyc - e0;
    per = m_ct + ((m_rt == 0) ? 1 : m_rt);
    if (m_mode == M_FIRING) begin
      for (int i = 0; i < NCH; i++) begin
        s = m_dly[i] + 1;
        if (m_act[i] && k >= s) begin
          off = k - s;
          if ((off / per) < m_np && (off % per) < m_ct) v[i] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  // Model update on each edge from the inputs presented for that edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_IDLE;
      m_fc   = 1'b0;
    end else begin
      cyc++;
      if (!bus.enable) begin
        m_mode = M_IDLE;
        m_fc   = 1'b1;
      end else if (bus.abort) begin
        m_mode = M_IDLE;
        m_fc   = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE, M_DONE: if (bus.arm) begin
            model_latch();
            m_fc = 1'b0;
            if (bus.fire) begin
              m_mode = M_FIRING;
              e0 = cyc;
            end else begin
              m_mode = M_ARMED;
            end
          end
          M_ARMED: if (bus.fire) begin
            m_mode = M_FIRING;
            e0 = cyc;
          end
          M_FIRING: if (cyc - e0 >= m_end) begin
            m_mode = M_DONE;
            m_fc   = 1'b1;
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", 64'(bus.transducerOutput), 64'(exp_out()));
      check("cyc_busy", 64'(bus.busy), 64'((m_mode == M_ARMED) || (m_mode == M_FIRING)));
      check("cyc_fc", 64'(bus.fireComplete), 64'(m_fc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_phase(input int step);
    for (int i = 0; i < NCH; i++) bus.phaseDelay[i*PD_W +: PD_W] = PD_W'(i * step);
  endtask

  initial begin
    logic [7:0] pat;
    bus.enable = 1'b1; bus.arm = 1'b0; bus.fire = 1'b0; bus.abort = 1'b0;
    bus.chanMask = '1; bus.chargeTime = '0; bus.restTime = '0; bus.pulseCount = '0;
    bus.fireDelay = '0; bus.phaseDelay = '0;

    // Reset state
    tick(2);
    check("rst_out", 64'(bus.transducerOutput), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_fc", 64'(bus.fireComplete), 64'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // Staggered single pulses, arm then fire
    bus.chanMask = 8'hFF; bus.fireDelay = 32'd10; set_phase(3);
    bus.chargeTime = 9'd5; bus.restTime = 16'd0; bus.pulseCount = 8'd1;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    check("a_armed_busy", 64'(bus.busy), 64'h1);
    bus.fire = 1'b1; tick(); bus.fire = 1'b0;
    bus.chargeTime = 9'd1; bus.fireDelay = '0; set_phase(0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      case (k)
        10: check("a_k10_out", 64'(bus.transducerOutput), 64'h00);
        11: check("a_k11_out", 64'(bus.transducerOutput), 64'h01);
        14: check("a_k14_out", 64'(bus.transducerOutput), 64'h03);
        16: check("a_k16_out", 64'(bus.transducerOutput), 64'h02);
        36: begin
          check("a_k36_out", 64'(bus.transducerOutput), 64'h80);
          check("a_k36_fc", 64'(bus.fireComplete), 64'h0);
        end
        37: begin
          check("a_k37_out", 64'(bus.transducerOutput), 64'h00);
          check("a_k37_fc", 64'(bus.fireComplete), 64'h1);
        end
        default: ;
      endcase
    end

    // Burst on ch0 with rest clamped, arm+fire together from DONE
    bus.chanMask = 8'h01; bus.fireDelay = '0; set_phase(0);
    bus.chargeTime = 9'd2; bus.restTime = 16'd0; bus.pulseCount = 8'd3;
    bus.arm = 1'b1; bus.fire = 1'b1; tick(); bus.arm = 1'b0; bus.fire = 1'b0;
    check("b_k0_fc", 64'(bus.fireComplete), 64'h0);
    pat = 8'b1101_1011;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 8) check("b_pattern", 64'(bus.transducerOutput[0]), 64'(pat[k-1]));
      if (k == 8) check("b_k8_fc", 64'(bus.fireComplete), 64'h0);
      if (k == 9) begin
        check("b_k9_out", 64'(bus.transducerOutput), 64'h0);
        check("b_k9_fc", 64'(bus.fireComplete), 64'h1);
      end
    end

    // Masked channels with zero charge time
    bus.chanMask = 8'b0000_0101; bus.chargeTime = 9'd0; bus.pulseCount = 8'd4;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    bus.fire = 1'b1; tick(); bus.fire = 1'b0;
    check("c_k0_busy", 64'(bus.busy), 64'h1);
    check("c_k0_fc", 64'(bus.fireComplete), 64'h0);
    tick();
    check("c_k1_fc", 64'(bus.fireComplete), 64'h1);
    check("c_k1_busy", 64'(bus.busy), 64'h0);
    check("c_k1_out", 64'(bus.transducerOutput), 64'h0);
    tick(3);

    // Abort during ch3's second pulse, then a lone fire is ignored
    bus.chanMask = 8'hFF; bus.fireDelay = 32'd2; set_phase(3);
    bus.chargeTime = 9'd4; bus.restTime = 16'd3; bus.pulseCount = 8'd3;
    bus.arm = 1'b1; bus.fire = 1'b1; tick(); bus.arm = 1'b0; bus.fire = 1'b0;
    tick(20);
    check("d_k20_out", 64'(bus.transducerOutput), 64'h2B);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("d_abort_out", 64'(bus.transducerOutput), 64'h0);
    check("d_abort_busy", 64'(bus.busy), 64'h0);
    check("d_abort_fc", 64'(bus.fireComplete), 64'h0);
    bus.fire = 1'b1; tick(3);
    check("d_fire_only_busy", 64'(bus.busy), 64'h0);
    check("d_fire_only_out", 64'(bus.transducerOutput), 64'h0);
    bus.fire = 1'b0; tick();

    // Enable dropped while ARMED
    bus.chargeTime = 9'd3; bus.restTime = 16'd0; bus.pulseCount = 8'd1;
    bus.fireDelay = '0; set_phase(0);
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    check("e_armed_busy", 64'(bus.busy), 64'h1);
    bus.enable = 1'b0; tick(); bus.enable = 1'b1;
    check("e_dis_busy", 64'(bus.busy), 64'h0);
    check("e_dis_fc", 64'(bus.fireComplete), 64'h1);
    tick();
    check("e_idle_fc_hold", 64'(bus.fireComplete), 64'h1);

    // Simultaneous arm+fire from IDLE with zero delays
    bus.arm = 1'b1; bus.fire = 1'b1; tick(); bus.arm = 1'b0; bus.fire = 1'b0;
    check("f_k0_out", 64'(bus.transducerOutput), 64'h00);
    check("f_k0_fc", 64'(bus.fireComplete), 64'h0);
    tick();
    check("f_k1_out", 64'(bus.transducerOutput), 64'hFF);
    tick();
    check("f_k2_out", 64'(bus.transducerOutput), 64'hFF);

    // Asynchronous reset while outputs are high
    #2 rst = 1'b0;
    #1;
    check("g_async_out", 64'(bus.transducerOutput), 64'h0);
    check("g_async_busy", 64'(bus.busy), 64'h0);
    check("g_async_fc", 64'(bus.fireComplete), 64'h0);
    tick(); rst = 1'b1; tick(2);

    // Asynchronous reset clears a held fireComplete
    bus.enable = 1'b0; tick(); bus.enable = 1'b1;
    check("h_fc_before", 64'(bus.fireComplete), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("h_async_fc", 64'(bus.fireComplete), 64'h0);
    tick(); rst = 1'b1; tick(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
